// File: rtl/cnn_pkg.sv
// Shared types and helpers for the sliding-window front end.
// Holds the line_window_gen FSM state encoding and the per-frame window count.
// No logic of its own; imported by line_window_gen.
package cnn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } lwg_state_t;

  // Number of K x K windows placed on an im_w x im_h image at the given stride.
  function automatic int win_count(input int im_w, input int im_h, input int k, input int stride);
    return ((im_h - k) / stride + 1) * ((im_w - k) / stride + 1);
  endfunction

endpackage

// File: rtl/line_delay.sv
// One image row of delay: an IM_W-deep shift register that advances only when enabled.
// Latency: o_dat is the sample written IM_W enabled cycles earlier (no reset; contents are don't-care until filled).
// Backpressure: none of its own; the parent holds i_en low to stall.
// Ports: i_clk clock, i_en shift enable, i_dat sample in, o_dat sample from one row back.
module line_delay #(
  parameter int DATA_W = 8,
  parameter int IM_W   = 28
) (
  input  logic              i_clk,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_dat,
  output logic [DATA_W-1:0] o_dat
);

  logic [DATA_W-1:0] r_mem [IM_W];

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      r_mem[0] <= i_dat;
      for (int i = 1; i < IM_W; i++) begin
        r_mem[i] <= r_mem[i-1];
      end
    end
  end

  assign o_dat = r_mem[IM_W-1];

endmodule

// File: rtl/line_window_gen.sv
// Raster pixel stream to K x K sliding windows (stride STRIDE) using K-1 row delays.
// Latency: a window is presented the cycle after its bottom-right pixel is accepted.
// Backpressure: pixels accepted only in RUN while the output register is empty or being drained.
// Ports: clk_i/rst_i (sync, active-high); start_i begins a frame from IDLE;
//   pix_i/pix_valid_i/pix_ready_o input stream; win_o/win_valid_o/win_ready_i/win_last_o
//   window stream, element (r,c) at win_o[(r*K+c)*DATA_W +: DATA_W]; busy_o, done_o status.
module line_window_gen
  import cnn_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IM_W   = 28,
  parameter int IM_H   = 28,
  parameter int K      = 3,
  parameter int STRIDE = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [DATA_W-1:0]     pix_i,
  input  logic                  pix_valid_i,
  output logic                  pix_ready_o,
  output logic [K*K*DATA_W-1:0] win_o,
  output logic                  win_valid_o,
  input  logic                  win_ready_i,
  output logic                  win_last_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int CW    = $clog2(IM_W);
  localparam int RW    = $clog2(IM_H);
  localparam int N_WIN = win_count(IM_W, IM_H, K, STRIDE);
  localparam int NW    = $clog2(N_WIN + 1);
  localparam logic [31:0] KM1 = 32'(K - 1);
  localparam logic [31:0] STR = 32'(STRIDE);

  generate
    if (K < 2 || K > IM_W || K > IM_H || STRIDE < 1) begin : g_bad_cfg
      $error("line_window_gen: illegal K/STRIDE/image size combination");
    end
  endgenerate

  lwg_state_t r_state, w_state_nxt;

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [NW-1:0] r_win_cnt;
  logic          r_last_seen;

  logic          w_pix_rdy;
  logic          w_accept;
  logic          w_start;
  logic          w_form;
  logic          w_frame_end;
  logic          w_last_hs;
  logic [31:0]   w_col_x;
  logic [31:0]   w_row_x;

  logic [K-1:0][DATA_W-1:0] w_tap;
  logic [DATA_W-1:0]        r_sw     [K][K];
  logic [DATA_W-1:0]        w_sw_nxt [K][K];
  logic [K*K*DATA_W-1:0]    w_win_flat;

  logic [K*K*DATA_W-1:0]    r_win;
  logic                     r_win_vld;
  logic                     r_win_last;

  // Accepting a pixel is only safe when the output register can take a window this cycle.
  assign w_pix_rdy   = (r_state == RUN) && (!r_win_vld || win_ready_i);
  assign w_accept    = pix_valid_i && w_pix_rdy;
  assign w_start     = (r_state == IDLE) && start_i;
  assign w_frame_end = (r_col == CW'(IM_W - 1)) && (r_row == RW'(IM_H - 1));
  assign w_last_hs   = r_win_vld && win_ready_i && r_win_last;

  assign w_col_x = 32'(r_col);
  assign w_row_x = 32'(r_row);
  assign w_form  = (w_col_x >= KM1) && (w_row_x >= KM1) &&
                   (((w_col_x - KM1) % STR) == 32'd0) &&
                   (((w_row_x - KM1) % STR) == 32'd0);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy_o      = 1'b1;
    done_o      = 1'b0;
    case (r_state)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) w_state_nxt = RUN;
      end
      RUN: begin
        if (w_accept && w_frame_end) w_state_nxt = FLUSH;
      end
      FLUSH: begin
        // The last window may already have drained while pixels were still arriving
        // (when the final pixel forms no window), hence the sticky flag.
        if (w_last_hs || r_last_seen) w_state_nxt = DONE;
      end
      DONE: begin
        done_o      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign pix_ready_o = w_pix_rdy;

  // ----------------------------------------------------------- counters
  always_ff @(posedge clk_i) begin
    if (rst_i || w_start) begin
      r_col       <= '0;
      r_row       <= '0;
      r_win_cnt   <= '0;
      r_last_seen <= 1'b0;
    end else begin
      if (w_accept) begin
        if (r_col == CW'(IM_W - 1)) begin
          r_col <= '0;
          r_row <= (r_row == RW'(IM_H - 1)) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
      if (w_accept && w_form) r_win_cnt <= r_win_cnt + 1'b1;
      if (w_last_hs)          r_last_seen <= 1'b1;
    end
  end

  // ------------------------------------------------- row delays + window
  // w_tap[j] is the pixel j rows above the incoming one, same column.
  assign w_tap[0] = pix_i;

  generate
    for (genvar g = 0; g < K - 1; g++) begin : g_rows
      line_delay #(
        .DATA_W (DATA_W),
        .IM_W   (IM_W)
      ) u_line_delay (
        .i_clk (clk_i),
        .i_en  (w_accept),
        .i_dat (w_tap[g]),
        .o_dat (w_tap[g+1])
      );
    end
  endgenerate

  // Window after shifting in the incoming column; top row (r=0) takes the oldest tap.
  always_comb begin
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) begin
        w_sw_nxt[r][c] = r_sw[r][c+1];
      end
      w_sw_nxt[r][K-1] = w_tap[K-1-r];
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_accept) r_sw <= w_sw_nxt;
  end

  always_comb begin
    w_win_flat = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        w_win_flat[(r*K+c)*DATA_W +: DATA_W] = w_sw_nxt[r][c];
      end
    end
  end

  // ------------------------------------------------------ output register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_win      <= '0;
      r_win_vld  <= 1'b0;
      r_win_last <= 1'b0;
    end else if (w_accept && w_form) begin
      r_win      <= w_win_flat;
      r_win_vld  <= 1'b1;
      r_win_last <= (r_win_cnt == NW'(N_WIN - 1));
    end else if (win_ready_i) begin
      r_win_vld  <= 1'b0;
      r_win_last <= 1'b0;
    end
  end

  assign win_o       = r_win;
  assign win_valid_o = r_win_vld;
  assign win_last_o  = r_win_last;

endmodule

// File: tb/tb_line_window_gen.sv
module tb_line_window_gen;

  typedef struct packed {
    logic [1:0]  dut;
    logic        last;
    logic [71:0] win;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [7:0]  pix;
  logic        pix_valid;
  logic        win_ready;
  logic        start     [3];
  logic        pix_ready [3];
  logic        win_valid [3];
  logic        win_last  [3];
  logic        busy      [3];
  logic        done      [3];
  logic [71:0] win0, win1;
  logic [31:0] win2;
  logic [71:0] wv [3];

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   win_cnt = 0;
  int   last_hs_cyc = -1;
  int   ready_mode = 0;
  logic [71:0] first_win;
  exp_t exp_q [$];
  logic [7:0]  tl_q [$];

  line_window_gen #(.DATA_W(8), .IM_W(28), .IM_H(28), .K(3), .STRIDE(1)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start[0]), .pix_i(pix), .pix_valid_i(pix_valid),
    .pix_ready_o(pix_ready[0]), .win_o(win0), .win_valid_o(win_valid[0]), .win_ready_i(win_ready),
    .win_last_o(win_last[0]), .busy_o(busy[0]), .done_o(done[0]));

  line_window_gen #(.DATA_W(8), .IM_W(8), .IM_H(8), .K(3), .STRIDE(2)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start[1]), .pix_i(pix), .pix_valid_i(pix_valid),
    .pix_ready_o(pix_ready[1]), .win_o(win1), .win_valid_o(win_valid[1]), .win_ready_i(win_ready),
    .win_last_o(win_last[1]), .busy_o(busy[1]), .done_o(done[1]));

  line_window_gen #(.DATA_W(8), .IM_W(6), .IM_H(6), .K(2), .STRIDE(4)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start[2]), .pix_i(pix), .pix_valid_i(pix_valid),
    .pix_ready_o(pix_ready[2]), .win_o(win2), .win_valid_o(win_valid[2]), .win_ready_i(win_ready),
    .win_last_o(win_last[2]), .busy_o(busy[2]), .done_o(done[2]));

  always_comb begin
    wv[0] = win0;
    wv[1] = win1;
    wv[2] = {40'd0, win2};
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int cfg_w(input int d);
    case (d)
      0:       return 28;
      1:       return 8;
      default: return 6;
    endcase
  endfunction

  function automatic int cfg_k(input int d);
    return (d == 2) ? 2 : 3;
  endfunction

  function automatic int cfg_s(input int d);
    case (d)
      0:       return 1;
      1:       return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [7:0] pix_val(input int seed, input int idx);
    return 8'((idx + seed * 37) % 256);
  endfunction

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Golden model: every window of a square frame, in emission order.
  task automatic push_frame(input int d, input int seed);
    int w, k, s, n;
    exp_t e;
    w = cfg_w(d); k = cfg_k(d); s = cfg_s(d);
    n = (w - k) / s + 1;
    for (int wr = 0; wr < n; wr++) begin
      for (int wc = 0; wc < n; wc++) begin
        e = '0;
        e.dut  = 2'(d);
        e.last = (wr == n - 1) && (wc == n - 1);
        for (int r = 0; r < k; r++)
          for (int c = 0; c < k; c++)
            e.win[(r*k+c)*8 +: 8] = pix_val(seed, (wr*s + r) * w + wc*s + c);
        exp_q.push_back(e);
      end
    end
  endtask

  // Scoreboard monitor: pops on every window handshake.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      if (win_valid[d] === 1'b1 && win_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_win dut=%0d actual=%h required=none", d, wv[d]);
        end else begin
          e = exp_q.pop_front();
          chk("win_dut", 72'(d), 72'(e.dut));
          chk("win_dat", wv[d], e.win);
          chk("win_last", 72'(win_last[d]), 72'(e.last));
        end
        if (win_cnt == 0) first_win = wv[d];
        win_cnt++;
        tl_q.push_back(wv[d][7:0]);
        if (win_last[d] === 1'b1) last_hs_cyc = cyc;
      end
    end
  end

  initial begin
    win_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       win_ready = 1'b1;
        1:       win_ready = 1'($urandom_range(0, 1));
        default: win_ready = 1'b0;
      endcase
    end
  end

  task automatic drive_frame(input int d, input int seed, input bit rnd, input int max_pix);
    int n, idx, used;
    bit acc;
    n = cfg_w(d) * cfg_w(d);
    if (max_pix < n) n = max_pix;
    push_frame(d, seed);
    win_cnt = 0;
    last_hs_cyc = -1;
    tl_q.delete();
    @(posedge clk); #1;
    start[d] = 1'b1;
    @(posedge clk); #1;
    start[d] = 1'b0;
    idx = 0;
    used = 0;
    while (idx < n && used < 40000) begin
      pix       = pix_val(seed, idx);
      pix_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start[d]  = rnd && (used == 200);
      @(negedge clk);
      acc = pix_valid && pix_ready[d];
      @(posedge clk); #1;
      if (acc) idx++;
      used++;
    end
    pix_valid = 1'b0;
    start[d]  = 1'b0;
    if (idx < n) begin
      checks++;
      failures++;
      $display("FAIL pix_timeout dut=%0d accepted=%0d required=%0d", d, idx, n);
    end
  endtask

  task automatic finish_frame(input int d, input int exp_cnt);
    bit got;
    int dcyc;
    got = 1'b0;
    dcyc = 0;
    for (int i = 0; i < 20000 && !got; i++) begin
      @(negedge clk);
      if (done[d] === 1'b1) begin
        got = 1'b1;
        dcyc = cyc;
      end
    end
    chk("done_seen", 72'(got), 72'(1));
    if (got) begin
      if (d == 1) chk("done_after_last", 72'(last_hs_cyc >= 0 && last_hs_cyc < dcyc), 72'(1));
      else        chk("done_timing", 72'(dcyc), 72'(last_hs_cyc + 1));
      @(negedge clk);
      chk("done_pulse", 72'(done[d]), 72'(0));
      chk("idle_after", 72'(busy[d]), 72'(0));
    end
    chk("win_count", 72'(win_cnt), 72'(exp_cnt));
    chk("queue_empty", 72'(exp_q.size()), 72'(0));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog cycles=%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [71:0] cap;
    int tl_a [9];
    int tl_b [4];
    tl_a = '{0, 2, 4, 16, 18, 20, 32, 34, 36};
    tl_b = '{0, 4, 24, 28};
    rst = 1'b1; pix = '0; pix_valid = 1'b0;
    for (int d = 0; d < 3; d++) start[d] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("rst_pix_ready", 72'(pix_ready[d]), 72'(0));
      chk("rst_win_valid", 72'(win_valid[d]), 72'(0));
      chk("rst_win_last", 72'(win_last[d]), 72'(0));
      chk("rst_busy", 72'(busy[d]), 72'(0));
      chk("rst_done", 72'(done[d]), 72'(0));
      chk("rst_win", wv[d], 72'(0));
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // Default frame, continuous flow.
    drive_frame(0, 0, 1'b0, 784);
    finish_frame(0, 676);
    chk("first_win", first_win, 72'h3A_39_38_1E_1D_1C_02_01_00);

    // Consumer stall mid-frame.
    fork
      drive_frame(0, 5, 1'b0, 784);
      begin
        repeat (300) @(posedge clk);
        #1 ready_mode = 2;
        repeat (4) @(negedge clk);
        cap = win0;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          chk("stall_pix_ready", 72'(pix_ready[0]), 72'(0));
          chk("stall_valid", 72'(win_valid[0]), 72'(1));
          chk("stall_win", win0, cap);
        end
        ready_mode = 0;
      end
    join
    finish_frame(0, 676);

    // 8x8, K=3, stride 2: final pixel forms no window.
    drive_frame(1, 0, 1'b0, 64);
    finish_frame(1, 9);
    chk("s2_tl_count", 72'(tl_q.size()), 72'(9));
    for (int i = 0; i < 9; i++)
      if (i < tl_q.size()) chk("s2_top_left", 72'(tl_q[i]), 72'(tl_a[i]));

    // 6x6, K=2, stride 4.
    drive_frame(2, 0, 1'b0, 36);
    finish_frame(2, 4);
    chk("s4_tl_count", 72'(tl_q.size()), 72'(4));
    for (int i = 0; i < 4; i++)
      if (i < tl_q.size()) chk("s4_top_left", 72'(tl_q[i]), 72'(tl_b[i]));

    // Reset after 100 pixels aborts the frame.
    drive_frame(0, 7, 1'b0, 100);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_pix_ready", 72'(pix_ready[0]), 72'(0));
    chk("mid_rst_valid", 72'(win_valid[0]), 72'(0));
    chk("mid_rst_last", 72'(win_last[0]), 72'(0));
    chk("mid_rst_busy", 72'(busy[0]), 72'(0));
    chk("mid_rst_done", 72'(done[0]), 72'(0));
    chk("mid_rst_win", win0, 72'(0));
    exp_q.delete();
    repeat (5) @(negedge clk);
    drive_frame(0, 9, 1'b0, 784);
    finish_frame(0, 676);

    // Random source/sink gaps over three back-to-back frames, with stray starts.
    ready_mode = 1;
    for (int f = 0; f < 3; f++) begin
      drive_frame(0, 11 + f, 1'b1, 784);
      finish_frame(0, 676);
    end
    ready_mode = 0;

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/line_window_gen.md
LINE_WINDOW_GEN -- requirements
Module: line_window_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 8: pixel width in bits.
REQ-002 SHALL have parameter IM_W, default 28: image width in pixels.
REQ-003 SHALL have parameter IM_H, default 28: image height in pixels.
REQ-004 SHALL have parameter K, default 3: square window dimension.
REQ-005 SHALL have parameter STRIDE, default 1: window step in both axes.
REQ-006 SHALL have port clk_i, input, 1 bit: single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port start_i, input, 1 bit: begins a frame, sampled only in IDLE.
REQ-009 SHALL have port pix_i, input, DATA_W bits: raster-order pixel.
REQ-010 SHALL have port pix_valid_i, input, 1 bit: pix_i is valid.
REQ-011 SHALL have port pix_ready_o, output, 1 bit: block accepts pix_i.
REQ-012 SHALL have port win_o, output, K*K*DATA_W bits: K x K window.
REQ-013 SHALL have port win_valid_o, output, 1 bit: win_o is valid.
REQ-014 SHALL have port win_ready_i, input, 1 bit: consumer accepts win_o.
REQ-015 SHALL have port win_last_o, output, 1 bit: final window of the frame.
REQ-016 SHALL have port busy_o, output, 1 bit: state is not IDLE.
REQ-017 SHALL have port done_o, output, 1 bit: one-cycle end-of-frame pulse.

Function
REQ-018 SHALL use FSM states IDLE, RUN, FLUSH, DONE with these transitions: IDLE->RUN on start_i; RUN->FLUSH on acceptance of pixel IM_W*IM_H-1; FLUSH->DONE on the win_last_o handshake; DONE->IDLE unconditionally.
REQ-019 SHALL accept a pixel only on a cycle where pix_valid_i and pix_ready_o are both high.
REQ-020 SHALL drive pix_ready_o = (state==RUN) and (!win_valid_o or win_ready_i).
REQ-021 SHALL track the column (0..IM_W-1) and row (0..IM_H-1) of each accepted pixel; the column wraps to 0 and the row increments after column IM_W-1.
REQ-022 SHALL hold K-1 row delays of IM_W pixels and a K x K shift window, all advancing only on pixel acceptance.
REQ-023 SHALL form a window when the accepted pixel has row>=K-1, col>=K-1, (row-K+1) mod STRIDE==0 and (col-K+1) mod STRIDE==0.
REQ-024 SHALL register each formed window into win_o with win_valid_o high on the cycle after acceptance of its bottom-right pixel, giving a latency of 1 cycle.
REQ-025 SHALL place window element (r,c), with r=0 as the top row and c=0 as the left column, at win_o[(r*K+c)*DATA_W +: DATA_W].
REQ-026 SHALL hold win_o, win_valid_o and win_last_o stable while win_valid_o is high and win_ready_i is low.
REQ-027 SHALL clear win_valid_o after a handshake unless a new window is loaded in the same cycle, giving back-to-back throughput of 1 window per cycle.
REQ-028 SHALL emit ((IM_H-K)/STRIDE+1)*((IM_W-K)/STRIDE+1) windows per frame, using integer division.
REQ-029 SHALL assert win_last_o only with the window at row K-1+((IM_H-K)/STRIDE)*STRIDE and col K-1+((IM_W-K)/STRIDE)*STRIDE.
REQ-030 SHALL, when the last pixel produces no window, end the frame on an internal last-window flag so that the FSM still reaches DONE via the handshake of the last emitted window.
REQ-031 SHALL ignore start_i outside IDLE.
REQ-032 SHALL keep pix_ready_o low in IDLE, FLUSH and DONE, and discard no input.
REQ-033 SHALL assert done_o only in the DONE state; busy_o SHALL be low only in IDLE.
REQ-034 SHALL zero the counters on each IDLE->RUN transition and leave line-buffer contents uncleared.
REQ-035 SHALL be elaborated only with K>=2, K<=IM_W, K<=IM_H and STRIDE>=1, with an elaboration-time assertion otherwise.

Reset
REQ-036 SHALL, on rst_i high at a clock edge, enter IDLE and clear the counters, win_valid_o, win_last_o, done_o and busy_o, and set pix_ready_o to 0.
REQ-037 SHALL abort any frame in progress when reset is asserted mid-operation; no window of that frame SHALL appear afterwards.
REQ-038 SHALL clear win_o to 0 on reset; line-buffer storage needs no reset.

Structure
REQ-039 SHALL place the FSM state enum and a window-count helper function in the shared package cnn_pkg.
REQ-040 SHALL instantiate sub-module line_delay (parameters DATA_W and IM_W; enable-gated one-row shift) K-1 times.

Verification
REQ-041 SHALL cover a default frame with pixels p=(row*28+col) mod 256, continuous valid and ready: 676 windows; first win_o = {0,1,2,28,29,30,56,57,58}; win_last_o on window 676; done_o one cycle after it.
REQ-042 SHALL cover win_ready_i held low for 10 cycles mid-frame: pix_ready_o low, win_o stable, no window lost or duplicated (count still 676).
REQ-043 SHALL cover STRIDE=2, IM_W=IM_H=8, K=3: 9 windows, top-left elements at (0,0),(0,2),...,(4,4); win_last_o on the 9th window.
REQ-044 SHALL cover IM_W=IM_H=6, K=2, STRIDE=4: 4 windows, at top-left (0,0),(0,4),(4,0),(4,4).
REQ-045 SHALL cover rst_i pulsed for 1 cycle after 100 pixels: outputs are at reset values next cycle; a following start_i frame yields a correct, complete 676-window output.
REQ-046 SHALL cover random pix_valid_i/win_ready_i gaps at 50% over 3 consecutive frames: every frame matches a golden model, and start_i pulses during RUN are ignored.
